// File: rtl/tron_fb_sweep_engine.sv
// Framebuffer sweep engine: full-screen fill, perimeter draw or conditional
// colour replace, driven by a single start/done handshake.
module tron_fb_sweep_engine #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 19,
  parameter int RD_LAT  = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] fill_color,
  input  logic [COLOR_W-1:0] match_color,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  ram_address,
  input  logic [COLOR_W-1:0] ram_read_data,
  output logic               ram_write_enabled,
  output logic [COLOR_W-1:0] ram_write_data
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_BORDER,
    S_RM_READ,
    S_RM_WAIT,
    S_RM_WRITE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [XW-1:0]      x, x_n;
  logic [YW-1:0]      y, y_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [1:0]         mode_q;
  logic [COLOR_W-1:0] fill_q, match_q;

  logic               last_x, last_y, edge_row, last_px;
  logic [XW-1:0]      rx_n;
  logic [YW-1:0]      ry_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      cnt     <= '0;
      mode_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      cnt   <= cnt_n;
      if (state == S_IDLE && start) begin
        mode_q  <= mode;
        fill_q  <= fill_color;
        match_q <= match_color;
      end
    end
  end

  always_comb begin
    last_x   = (x == XW'(WIDTH - 1));
    last_y   = (y == YW'(HEIGHT - 1));
    edge_row = (y == '0) || last_y;
    last_px  = last_x && last_y;
    if (last_x) begin
      rx_n = '0;
      ry_n = y + 1'b1;
    end else begin
      rx_n = x + 1'b1;
      ry_n = y;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          x_n = '0;
          y_n = '0;
          unique case (mode)
            2'd0:    state_n = S_FILL;
            2'd1:    state_n = S_BORDER;
            2'd2:    state_n = S_RM_READ;
            default: state_n = S_DONE;
          endcase
        end
      end
      S_FILL: begin
        if (last_px) state_n = S_DONE;
        else begin
          x_n = rx_n;
          y_n = ry_n;
        end
      end
      S_BORDER: begin
        if (last_px) state_n = S_DONE;
        else if (!edge_row && x == '0) x_n = XW'(WIDTH - 1);
        else begin
          // interior rows jump from x=0 to the right edge, then wrap to the next row
          x_n = rx_n;
          y_n = ry_n;
        end
      end
      S_RM_READ: begin
        cnt_n   = '0;
        state_n = (RD_LAT == 1) ? S_RM_WRITE : S_RM_WAIT;
      end
      S_RM_WAIT: begin
        if (int'(cnt) >= RD_LAT - 2) state_n = S_RM_WRITE;
        else cnt_n = cnt + 1'b1;
      end
      S_RM_WRITE: begin
        if (last_px) state_n = S_DONE;
        else begin
          state_n = S_RM_READ;
          x_n     = rx_n;
          y_n     = ry_n;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (busy && abort) begin
      state_n = S_IDLE;
      x_n     = '0;
      y_n     = '0;
      cnt_n   = '0;
    end
  end

  always_comb begin
    busy = (state == S_FILL) || (state == S_BORDER) || (state == S_RM_READ) ||
           (state == S_RM_WAIT) || (state == S_RM_WRITE);
    done = (state == S_DONE);
    ram_address = '0;
    if (busy) ram_address = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    ram_write_data    = busy ? fill_q : '0;
    ram_write_enabled = !abort &&
                        ((state == S_FILL) || (state == S_BORDER) ||
                         ((state == S_RM_WRITE) && (ram_read_data == match_q)));
  end

  logic unused_mode;
  assign unused_mode = ^mode_q;

endmodule

// File: tb/tb_tron_fb_sweep_engine.sv
// Self-checking bench for tron_fb_sweep_engine on an 8x4 framebuffer with a
// two-cycle-latency RAM model; expected write traces come from the sweep rules.
module tb_tron_fb_sweep_engine;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 3;
  localparam int AW = 5;
  localparam int RL = 2;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] fill_color = '0;
  logic [CW-1:0] match_color = '0;
  logic          abort = 1'b0;
  logic          busy, done, ram_write_enabled;
  logic [AW-1:0] ram_address;
  logic [CW-1:0] ram_read_data, ram_write_data;

  tron_fb_sweep_engine #(
    .WIDTH(W), .HEIGHT(H), .COLOR_W(CW), .ADDR_W(AW), .RD_LAT(RL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .fill_color(fill_color), .match_color(match_color), .abort(abort),
    .busy(busy), .done(done), .ram_address(ram_address),
    .ram_read_data(ram_read_data), .ram_write_enabled(ram_write_enabled),
    .ram_write_data(ram_write_data)
  );

  always #5 clock = ~clock;

  // RAM model with RL-cycle read latency; pre_mem is copied in on load
  logic [CW-1:0] mem [NPIX];
  logic [CW-1:0] pre_mem [NPIX];
  logic [CW-1:0] p1, p2;
  logic          load = 1'b0;
  assign ram_read_data = p2;

  always @(posedge clock) begin
    if (load) mem <= pre_mem;
    else if (ram_write_enabled) mem[ram_address] <= ram_write_data;
    p1 <= mem[ram_address];
    p2 <= p1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_a[$], exp_c[$], got_a[$], got_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected (address, cycle-after-start) pairs from the sweep definitions
  function automatic void build_exp(input int m, input logic [CW-1:0] mc);
    int idx = 0;
    exp_a.delete();
    exp_c.delete();
    for (int a = 0; a < NPIX; a++) begin
      int px = a % W;
      int py = a / W;
      if (m == 0) begin
        exp_a.push_back(a); exp_c.push_back(a + 1);
      end else if (m == 1) begin
        if (py == 0 || py == H - 1 || px == 0 || px == W - 1) begin
          idx++;
          exp_a.push_back(a); exp_c.push_back(idx);
        end
      end else if (m == 2) begin
        if (pre_mem[a] == mc) begin
          exp_a.push_back(a); exp_c.push_back((RL + 1) * a + RL + 1);
        end
      end
    end
  endfunction

  task automatic load_mem();
    @(posedge clock); #1 load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
  endtask

  // Runs one sweep; end_n is the cycle where busy must be low again.
  task automatic run(input logic [1:0] m, input logic [CW-1:0] fc, input logic [CW-1:0] mc,
                     input int abort_at, input int spur_at, input int end_n, input bit exp_done);
    int n = 0;
    bit fin = 0;
    got_a.delete();
    got_c.delete();
    @(posedge clock); #1;
    start = 1'b1; mode = m; fill_color = fc; match_color = mc;
    while (!fin && n < 1000) begin
      @(posedge clock); #1;
      n++;
      start = (n == spur_at);
      mode  = (n == spur_at) ? 2'd1 : m;
      abort = (n == abort_at);
      @(negedge clock);
      if (ram_write_enabled) begin
        got_a.push_back(int'(ram_address));
        got_c.push_back(n);
        chk("wdata", ram_write_data, fc);
      end
      if (n == end_n) begin
        chk("done_at_end", done, exp_done);
        chk("busy_at_end", busy, 0);
        chk("addr_at_end", ram_address, 0);
        fin = 1;
      end else begin
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
      end
    end
    abort = 1'b0;
    chk("sweep_finished", fin, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_we", ram_write_enabled, 0);
    chk("write_count", got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk("write_addr", got_a[i], exp_a[i]);
      chk("write_cycle", got_c[i], exp_c[i]);
    end
  endtask

  initial begin
    logic [CW-1:0] rc, rm;
    for (int i = 0; i < NPIX; i++) pre_mem[i] = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", ram_write_enabled, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_wdata", ram_write_data, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    load_mem();

    build_exp(0, '0);
    run(2'd0, 3'b111, 3'b000, 0, 0, NPIX + 1, 1);
    build_exp(1, '0);
    run(2'd1, 3'b111, 3'b000, 0, 0, 2 * W + 2 * (H - 2) + 1, 1);

    for (int i = 0; i < NPIX; i++) pre_mem[i] = 3'b010;
    pre_mem[5]  = 3'b100;
    pre_mem[17] = 3'b100;
    load_mem();
    build_exp(2, 3'b100);
    run(2'd2, 3'b000, 3'b100, 0, 0, (RL + 1) * NPIX + 1, 1);

    // abort during the 10th busy cycle: only addresses 0..8 written
    build_exp(0, '0);
    for (int i = 0; i < NPIX - 9; i++) begin
      void'(exp_a.pop_back()); void'(exp_c.pop_back());
    end
    run(2'd0, 3'b101, 3'b000, 10, 0, 11, 0);
    build_exp(0, '0);
    run(2'd0, 3'b101, 3'b000, 0, 0, NPIX + 1, 1);

    // start with mode=1 during FILL must be ignored
    build_exp(0, '0);
    run(2'd0, 3'b011, 3'b000, 0, 5, NPIX + 1, 1);
    build_exp(3, '0);
    run(2'd3, 3'b011, 3'b000, 0, 0, 1, 1);

    // randomized sweeps
    for (int t = 0; t < 3; t++) begin
      rc = CW'($urandom_range(0, 7));
      rm = CW'($urandom_range(0, 7));
      for (int i = 0; i < NPIX; i++)
        pre_mem[i] = ($urandom_range(0, 2) == 0) ? rm : CW'($urandom_range(0, 7));
      load_mem();
      build_exp(2, rm);
      run(2'd2, rc, rm, 0, 0, (RL + 1) * NPIX + 1, 1);
      rc = CW'($urandom_range(0, 7));
      build_exp(t % 2, '0);
      run(2'((t % 2)), rc, 3'b000, 0, 0,
          (t % 2 == 0) ? NPIX + 1 : 2 * W + 2 * (H - 2) + 1, 1);
    end

    // reset asserted in the 5th RM_WAIT cycle (pixel 4, cycle 14)
    @(posedge clock); #1;
    start = 1'b1; mode = 2'd2; fill_color = 3'b110; match_color = 3'b000;
    @(posedge clock); #1 start = 1'b0;
    repeat (13) @(posedge clock);
    #1;
    chk("wait_busy", busy, 1);
    chk("wait_addr", ram_address, 4);
    chk("wait_we", ram_write_enabled, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_we", ram_write_enabled, 0);
    chk("arst_addr", ram_address, 0);
    chk("arst_wdata", ram_write_data, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    build_exp(3, '0);
    run(2'd3, 3'b001, 3'b000, 0, 0, 1, 1);
    build_exp(0, '0);
    run(2'd0, 3'b001, 3'b000, 0, 0, NPIX + 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
